// File: rtl/b_handler_pkg.sv
// Shared traffic-generator types: AXI response codes, B channel payload and
// the transaction descriptor used by the AW, W and B handlers.
package b_handler_pkg;

    localparam int ID_W  = 4;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_channel_t;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [7:0]      burst_len;
    } trans_data_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        DONE      = 2'd2
    } b_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/b_handler_up_down_counter.sv
// Up/down counter with clear and a hold-at-maximum ceiling; overflow flags an
// increment refused because the ceiling was reached.
module up_down_counter #(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        overflow   = 1'b0;
        if (clear) begin
            // A same-cycle increment survives the clear
            count_next = inc ? WIDTH'(1) : '0;
        end else if (inc && !dec) begin
            if (count_reg == MAX_C) overflow = 1'b1;
            else                    count_next = count_reg + WIDTH'(1);
        end else if (dec && !inc && count_reg != '0) begin
            count_next = count_reg - WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count_reg <= '0;
        else       count_reg <= count_next;
    end

    assign count = count_reg;

endmodule

// File: rtl/b_handler.sv
// Write-response stage: accepts B responses against issued AW handshakes,
// checks BID/BRESP and reports completion and error status.
module b_handler
    import b_handler_pkg::*;
#(
    parameter type b_channel_t_p  = b_handler_pkg::b_channel_t,
    parameter type trans_data_t_p = b_handler_pkg::trans_data_t,
    parameter int  MaxOutstanding = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          b_valid_i,
    input  b_channel_t_p  b_data_i,
    output logic          b_ready_o,
    input  logic          aw_issued_i,
    input  trans_data_t_p trans_data_i,
    input  logic          enable_i,
    output logic          ready_o,
    output logic          done_o,
    output logic          err_o,
    output logic [7:0]    err_count_o,
    output logic [7:0]    outstanding_o
);

    b_state_e      state_reg, state_next;
    trans_data_t_p trans_reg, trans_next;
    logic [7:0]    received_reg, received_next;
    logic [7:0]    err_count_reg, err_count_next;
    logic          err_reg, err_next;

    logic       cnt_clear;
    logic       cnt_overflow;
    logic       handshake;
    logic       bad_resp;
    logic [7:0] outstanding;

    up_down_counter #(
        .WIDTH   (8),
        .MAX_VAL (MaxOutstanding)
    ) u_outstanding (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear    (cnt_clear),
        .inc      (aw_issued_i),
        .dec      (handshake),
        .count    (outstanding),
        .overflow (cnt_overflow)
    );

    assign handshake = b_valid_i && b_ready_o;
    assign bad_resp  = (b_data_i.resp != 2'(RESP_OKAY)) || (b_data_i.id != trans_reg.id);

    always_comb begin
        state_next     = state_reg;
        trans_next     = trans_reg;
        received_next  = received_reg;
        err_count_next = err_count_reg;
        err_next       = err_reg;
        cnt_clear      = 1'b0;
        ready_o        = 1'b0;
        b_ready_o      = 1'b0;
        done_o         = 1'b0;

        unique case (state_reg)
            IDLE: begin
                ready_o    = 1'b1;
                trans_next = trans_data_i;
                if (enable_i) begin
                    received_next  = '0;
                    err_count_next = '0;
                    err_next       = 1'b0;
                    cnt_clear      = 1'b1;
                    state_next     = (trans_data_i.burst_len == 8'd0) ? DONE : WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // Never accept a response whose AW has not yet gone out
                b_ready_o = (outstanding != 8'd0);
                if (handshake) begin
                    received_next = received_reg + 8'd1;
                    if (bad_resp) begin
                        err_next       = 1'b1;
                        err_count_next = sat_inc(err_count_reg);
                    end
                    if (received_reg == 8'(trans_reg.burst_len - 8'd1)) state_next = DONE;
                end
            end
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (cnt_overflow) err_next = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= IDLE;
            trans_reg     <= '0;
            received_reg  <= '0;
            err_count_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            trans_reg     <= trans_next;
            received_reg  <= received_next;
            err_count_reg <= err_count_next;
            err_reg       <= err_next;
        end
    end

    assign err_o         = err_reg;
    assign err_count_o   = err_count_reg;
    assign outstanding_o = outstanding;

endmodule
